// File: rtl/pulse_gen.sv
// Pulse-train generator: N pulses of H cycles high separated by L-cycle gaps,
// with a one-cycle DONE strobe on completion and an abort path back to idle.
module pulse_gen #(
  parameter int CNT_W = 8
) (
  input  logic             SYS_CLK,
  input  logic             A_RESET,
  input  logic             START,
  input  logic [CNT_W-1:0] HIGH_LEN,
  input  logic [CNT_W-1:0] LOW_LEN,
  input  logic [CNT_W-1:0] NUM_PULSES,
  input  logic             ABORT,
  output logic             PULSE,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] PULSE_IDX
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] h_len, h_len_nxt;
  logic [CNT_W-1:0] l_len, l_len_nxt;
  logic [CNT_W-1:0] n_pulses, n_pulses_nxt;
  logic             pulse_ff, busy_ff, done_ff;

  // A zero length behaves as one cycle, so the counter load is never negative.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    if (len == ZERO) begin
      len_m1 = ZERO;
    end else begin
      len_m1 = len - ONE;
    end
  endfunction

  // Next-state, counter and capture logic.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    h_len_nxt    = h_len;
    l_len_nxt    = l_len;
    n_pulses_nxt = n_pulses;
    case (state)
      IDLE: begin
        if (START && !ABORT) begin
          h_len_nxt    = HIGH_LEN;
          l_len_nxt    = LOW_LEN;
          n_pulses_nxt = NUM_PULSES;
          idx_nxt      = ZERO;
          if (NUM_PULSES == ZERO) begin
            state_nxt = FIN;
          end else begin
            state_nxt = HIGH;
            cnt_nxt   = len_m1(HIGH_LEN);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      HIGH: begin
        if (ABORT) begin
          state_nxt = IDLE;
        end else if (cnt == ZERO) begin
          idx_nxt = idx + ONE;
          // idx never exceeds N-1 here, so idx+1 cannot wrap.
          if ((idx + ONE) == n_pulses) begin
            state_nxt = FIN;
          end else begin
            state_nxt = LOW;
            cnt_nxt   = len_m1(l_len);
          end
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      LOW: begin
        if (ABORT) begin
          state_nxt = IDLE;
        end else if (cnt == ZERO) begin
          state_nxt = HIGH;
          cnt_nxt   = len_m1(h_len);
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and captured lengths.
  always_ff @(posedge SYS_CLK or posedge A_RESET) begin
    if (A_RESET) begin
      state    <= IDLE;
      cnt      <= ZERO;
      idx      <= ZERO;
      h_len    <= ZERO;
      l_len    <= ZERO;
      n_pulses <= ZERO;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      h_len    <= h_len_nxt;
      l_len    <= l_len_nxt;
      n_pulses <= n_pulses_nxt;
    end
  end

  // Output flops mirror the decode of the state register, one flop per output.
  always_ff @(posedge SYS_CLK or posedge A_RESET) begin
    if (A_RESET) begin
      pulse_ff <= 1'b0;
      busy_ff  <= 1'b0;
      done_ff  <= 1'b0;
    end else begin
      pulse_ff <= (state_nxt == HIGH);
      busy_ff  <= (state_nxt == HIGH) || (state_nxt == LOW);
      done_ff  <= (state_nxt == FIN);
    end
  end

  assign PULSE     = pulse_ff;
  assign BUSY      = busy_ff;
  assign DONE      = done_ff;
  assign PULSE_IDX = idx;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed, table-driven bench for pulse_gen: per-cycle waveform masks for
// several trains plus hand-written restart, mid-train reset and long-pulse cases.
module tb_pulse_gen;

  logic       SYS_CLK = 1'b0;
  logic       A_RESET;
  logic       START;
  logic [7:0] HIGH_LEN;
  logic [7:0] LOW_LEN;
  logic [7:0] NUM_PULSES;
  logic       ABORT;
  logic       PULSE;
  logic       BUSY;
  logic       DONE;
  logic [7:0] PULSE_IDX;

  int tests = 0;
  int fails = 0;

  pulse_gen #(.CNT_W(8)) dut (
    .SYS_CLK    (SYS_CLK),
    .A_RESET    (A_RESET),
    .START      (START),
    .HIGH_LEN   (HIGH_LEN),
    .LOW_LEN    (LOW_LEN),
    .NUM_PULSES (NUM_PULSES),
    .ABORT      (ABORT),
    .PULSE      (PULSE),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .PULSE_IDX  (PULSE_IDX)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic [7:0]  h;
    logic [7:0]  l;
    logic [7:0]  n;
    int          abort_cyc;
    logic [15:0] pmask;
    logic [15:0] bmask;
    logic [15:0] dmask;
    logic [7:0]  idx;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a train at edge 0 and compares PULSE/BUSY/DONE in cycles 0..15.
  // restart_cyc >= 0 re-asserts START with HIGH_LEN=7 during that cycle.
  task automatic run_train(input vec_t v, input int id, input int restart_cyc);
    @(negedge SYS_CLK);
    HIGH_LEN   = v.h;
    LOW_LEN    = v.l;
    NUM_PULSES = v.n;
    ABORT      = 1'b0;
    START      = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge SYS_CLK);
      #1;
      START = (c == restart_cyc);
      if (c == restart_cyc) HIGH_LEN = 8'd7;
      ABORT = (c == v.abort_cyc);
      @(negedge SYS_CLK);
      check($sformatf("v%0d c%0d PULSE", id, c), {31'd0, PULSE}, {31'd0, v.pmask[c]});
      check($sformatf("v%0d c%0d BUSY", id, c),  {31'd0, BUSY},  {31'd0, v.bmask[c]});
      check($sformatf("v%0d c%0d DONE", id, c),  {31'd0, DONE},  {31'd0, v.dmask[c]});
    end
    check($sformatf("v%0d PULSE_IDX", id), {24'd0, PULSE_IDX}, {24'd0, v.idx});
  endtask

  initial begin
    int n_high;
    int done_cyc;

    vecs[0] = '{8'd3, 8'd2, 8'd2, -1, 16'h00E7, 16'h00FF, 16'h0100, 8'd2};
    vecs[1] = '{8'd3, 8'd2, 8'd0, -1, 16'h0000, 16'h0000, 16'h0001, 8'd0};
    vecs[2] = '{8'd0, 8'd0, 8'd3, -1, 16'h0015, 16'h001F, 16'h0020, 8'd3};
    vecs[3] = '{8'd3, 8'd2, 8'd2,  1, 16'h0003, 16'h0003, 16'h0000, 8'd0};
    vecs[4] = '{8'd1, 8'd3, 8'd1, -1, 16'h0001, 16'h0001, 16'h0002, 8'd1};
    vecs[5] = '{8'd2, 8'd1, 8'd3, -1, 16'h00DB, 16'h00FF, 16'h0100, 8'd3};
    vecs[6] = '{8'd2, 8'd3, 8'd2,  3, 16'h0003, 16'h000F, 16'h0000, 8'd1};

    A_RESET    = 1'b1;
    START      = 1'b0;
    ABORT      = 1'b0;
    HIGH_LEN   = 8'd0;
    LOW_LEN    = 8'd0;
    NUM_PULSES = 8'd0;
    #12;
    check("reset PULSE", {31'd0, PULSE}, 32'd0);
    check("reset BUSY",  {31'd0, BUSY},  32'd0);
    check("reset DONE",  {31'd0, DONE},  32'd0);
    check("reset IDX",   {24'd0, PULSE_IDX}, 32'd0);
    @(negedge SYS_CLK);
    A_RESET = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_train(vecs[i], i, -1);
    end

    // START re-asserted with a new HIGH_LEN mid-train must not disturb it.
    run_train(vecs[0], 10, 4);

    // ABORT together with START in IDLE: nothing starts.
    @(negedge SYS_CLK);
    HIGH_LEN = 8'd3; LOW_LEN = 8'd2; NUM_PULSES = 8'd2;
    START = 1'b1; ABORT = 1'b1;
    @(posedge SYS_CLK);
    #1;
    START = 1'b0; ABORT = 1'b0;
    @(negedge SYS_CLK);
    check("abort+start BUSY", {31'd0, BUSY}, 32'd0);
    check("abort+start DONE", {31'd0, DONE}, 32'd0);

    // Reset pulsed mid-cycle 1 drops everything before the next edge.
    @(negedge SYS_CLK);
    START = 1'b1;
    @(posedge SYS_CLK);
    #1;
    START = 1'b0;
    @(posedge SYS_CLK);
    #2;
    check("pre-reset PULSE", {31'd0, PULSE}, 32'd1);
    A_RESET = 1'b1;
    #1;
    check("mid-reset PULSE", {31'd0, PULSE}, 32'd0);
    check("mid-reset BUSY",  {31'd0, BUSY},  32'd0);
    check("mid-reset IDX",   {24'd0, PULSE_IDX}, 32'd0);
    #1;
    A_RESET = 1'b0;
    run_train(vecs[0], 20, -1);

    // Maximum high length: 255 high cycles, no wrap, DONE right after.
    @(negedge SYS_CLK);
    HIGH_LEN = 8'd255; LOW_LEN = 8'd1; NUM_PULSES = 8'd1;
    START = 1'b1;
    n_high = 0;
    done_cyc = -1;
    for (int c = 0; c < 400; c++) begin
      @(posedge SYS_CLK);
      #1;
      START = 1'b0;
      @(negedge SYS_CLK);
      if (PULSE) n_high++;
      if (DONE) begin
        done_cyc = c;
        break;
      end
    end
    check("long high cycles", n_high, 32'd255);
    check("long done cycle", done_cyc, 32'd255);
    check("long IDX", {24'd0, PULSE_IDX}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of all length and count fields.
REQ-002 SHALL have port SYS_CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port A_RESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port START  input  1  request to begin a pulse train.
REQ-005 SHALL have port HIGH_LEN  input  CNT_W  pulse high time, in SYS_CLK cycles.
REQ-006 SHALL have port LOW_LEN  input  CNT_W  gap between pulses, in SYS_CLK cycles.
REQ-007 SHALL have port NUM_PULSES  input  CNT_W  number of pulses in the train.
REQ-008 SHALL have port ABORT  input  1  terminate the train in progress.
REQ-009 SHALL have port PULSE  output  1  generated pulse, registered.
REQ-010 SHALL have port BUSY  output  1  train in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle strobe on normal completion.
REQ-012 SHALL have port PULSE_IDX  output  CNT_W  count of pulses completed in the current or last train.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, HIGH, LOW and FIN; outputs SHALL decode from registered state only.
REQ-014 Output decode SHALL be:
- PULSE=1 only in HIGH.
- BUSY=1 only in HIGH or LOW.
- DONE=1 only in FIN.
REQ-015 START SHALL be accepted only in IDLE; START in any other state SHALL be ignored.
REQ-016 On accepting START, the block SHALL capture HIGH_LEN, LOW_LEN and NUM_PULSES into internal registers; later input changes SHALL NOT affect the running train.
REQ-017 On accepting START, the block SHALL clear PULSE_IDX.
REQ-018 A HIGH_LEN or LOW_LEN value of 0 SHALL be treated as 1.
REQ-019 Timing SHALL be as follows (cycle c = interval after rising edge c; START sampled at edge 0):
- PULSE high for cycles 0..H-1.
- PULSE low for L cycles.
- This repeats N times.
- No trailing gap after the last pulse.
REQ-020 FSM transitions SHALL be:
- IDLE->HIGH on START with N>0.
- IDLE->FIN on START with N=0.
- HIGH->LOW at end of high time if more pulses remain.
- HIGH->FIN at end of the last pulse's high time.
- LOW->HIGH at end of low time.
- FIN->IDLE unconditionally.
REQ-021 FIN SHALL occupy exactly one cycle: cycle N*H+(N-1)*L, or cycle 0 when N=0.
REQ-022 Length timing SHALL use a CNT_W down-counter loaded with (len-1) on entry to HIGH or LOW; the phase SHALL end when the counter is 0.
REQ-023 PULSE_IDX SHALL increment by 1 on each HIGH exit.
REQ-024 PULSE_IDX SHALL hold its value in IDLE until the next accepted START.
REQ-025 ABORT sampled high in HIGH or LOW SHALL force the next state to IDLE: PULSE=0 and BUSY=0 next cycle, no DONE, and PULSE_IDX held.
REQ-026 ABORT SHALL override simultaneous START in IDLE, so no train starts.
REQ-027 ABORT in FIN SHALL have no effect.
REQ-028 N=2^CNT_W-1 and H or L=2^CNT_W-1 SHALL run to completion without counter wrap.
REQ-029 PULSE SHALL be glitch-free, driven directly from a flop.

Reset
REQ-030 While A_RESET=1, the state SHALL be IDLE, without waiting for a clock edge.
REQ-031 While A_RESET=1, PULSE=0, BUSY=0, DONE=0 and PULSE_IDX=0.
REQ-032 While A_RESET=1, all captured length registers and counters SHALL be 0.
REQ-033 Reset asserted mid-train SHALL drop PULSE within the same cycle.
REQ-034 After reset release, the block SHALL accept START at the first rising edge at which A_RESET=0.

Verification
REQ-035 Bench SHALL cover H=3, L=2, N=2, START at edge 0 -> PULSE high in cycles 0-2 and 5-7, low in 3-4; DONE in cycle 8 only; PULSE_IDX=2; BUSY low from cycle 8.
REQ-036 Bench SHALL cover N=0 -> PULSE never high, BUSY never high, DONE in cycle 0, PULSE_IDX=0.
REQ-037 Bench SHALL cover H=0, L=0, N=3 -> PULSE high in cycles 0, 2 and 4; DONE in cycle 5; PULSE_IDX=3.
REQ-038 Bench SHALL cover the REQ-035 setup with ABORT high during cycle 1 -> PULSE=0 and BUSY=0 from cycle 2, DONE never asserted, PULSE_IDX=0.
REQ-039 Bench SHALL cover the REQ-035 setup with START re-asserted and HIGH_LEN changed to 7 in cycle 4 -> waveform identical to REQ-035.
REQ-040 Bench SHALL cover A_RESET pulsed mid-cycle 1 of a train -> PULSE, BUSY and PULSE_IDX go to 0 before the next edge; a new START afterwards gives a waveform matching REQ-035.
